// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// seven_segment_scan_driver -- double-buffered, blanked hex digit scanner
// Rev 1.0
// ============================================================================
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                enable,
  input  logic                                                load,
  input  logic [4*NUM_DIGITS-1:0]                             value_in,
  input  logic                                                lz_suppress,
  output logic [3:0]                                          bcd,
  output logic [NUM_DIGITS-1:0]                               an,
  output logic [$clog2(NUM_DIGITS > 1 ? NUM_DIGITS : 2)-1:0] digit_idx,
  output logic                                                frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS > 1 ? NUM_DIGITS : 2);
  localparam int DIV_W = $clog2(REFRESH_DIV > 1 ? REFRESH_DIV : 2);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                    state;
  logic [DIV_W-1:0]          div;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic [4*NUM_DIGITS-1:0]   display;

  logic [DIV_W-1:0]          div_n;
  logic [IDX_W-1:0]          idx_n;
  logic                      wrap;
  logic [4*NUM_DIGITS-1:0]   display_n;
  logic [3:0]                nib_n;
  logic                      blank_n;
  logic                      suppress;

  // Next slot position; leaving IDLE always starts a fresh digit-0 slot.
  always_comb begin
    div_n = '0;
    idx_n = '0;
    wrap  = 1'b0;
    if (enable && (state != IDLE)) begin
      if (div == DIV_LAST) begin
        if (digit_idx == IDX_LAST) wrap = 1'b1;
        else                       idx_n = digit_idx + IDX_W'(1);
      end else begin
        div_n = div + DIV_W'(1);
        idx_n = digit_idx;
      end
    end
  end

  // Display only swaps at a frame wrap or while idle, so a frame is never torn.
  always_comb begin
    display_n = display;
    if ((state == IDLE) || wrap)
      display_n = load ? value_in : shadow;
  end

  assign nib_n   = display_n[{idx_n, 2'b00} +: 4];
  assign blank_n = (div_n < BLANK_END);

  always_comb begin
    suppress = lz_suppress && (idx_n != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_n)) && (display_n[4*k +: 4] != 4'h0))
        suppress = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      digit_idx  <= '0;
      shadow     <= '0;
      display    <= '0;
      bcd        <= 4'h0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      div       <= div_n;
      digit_idx <= idx_n;
      display   <= display_n;
      if (load) shadow <= value_in;
      if (!enable) begin
        state      <= IDLE;
        an         <= '1;
        bcd        <= 4'h0;
        frame_tick <= 1'b0;
      end else begin
        frame_tick <= wrap;
        bcd        <= nib_n;
        if (blank_n) begin
          state <= BLANK;
          an    <= '1;
        end else begin
          state <= DRIVE;
          an    <= suppress ? '1 : ~(NUM_DIGITS'(1) << idx_n);
        end
      end
    end
  end

endmodule
`default_nettype wire
